// File: rtl/firbank_32_48_sequencer.sv
// Scheduler for the 32->48 kHz polyphase upsampler (L=3, M=2).
// Tracks the polyphase index, pulls input samples into a TAPS-deep history
// ring and, per output tick, sequences one TAPS-long dot product through the
// coefficient ROM, the history RAM and the external MAC.
module firbank_32_48_sequencer #(
   parameter int unsigned TAPS   = 16,
   parameter int unsigned NPHASE = 3,
   parameter int unsigned DECIM  = 2,
   parameter int unsigned RD_LAT = 1,
   localparam int unsigned HAW   = $clog2(TAPS),
   localparam int unsigned PW    = $clog2(NPHASE),
   localparam int unsigned RAW   = $clog2(NPHASE * TAPS)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           out_tick,
   input  logic           in_valid,
   output logic           in_ready,
   output logic           hist_we,
   output logic [HAW-1:0] hist_waddr,
   output logic [RAW-1:0] rom_addr,
   output logic [HAW-1:0] hist_raddr,
   output logic           mac_clr,
   output logic           mac_en,
   output logic           out_valid,
   output logic [PW-1:0]  cur_phase,
   output logic           overrun
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_MAC,
      ST_DRAIN,
      ST_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [PW-1:0]     phase_q, phase_d;
   logic [PW-1:0]     cur_phase_q, cur_phase_d;
   logic [HAW-1:0]    wr_ptr_q, wr_ptr_d;
   logic              pending_q, pending_d;
   logic [HAW-1:0]    k_q, k_d;
   logic [RAW-1:0]    rom_addr_q, rom_addr_d;
   logic [HAW-1:0]    hist_raddr_q, hist_raddr_d;
   logic [RD_LAT-1:0] en_pipe_q, en_pipe_d;
   logic [RD_LAT-1:0] clr_pipe_q, clr_pipe_d;

   logic [PW:0]       phase_sum;
   logic              need;
   logic [PW-1:0]     phase_next;
   logic              start;
   logic              issue;
   logic              xfer;
   logic              overrun_c;
   logic [RAW-1:0]    rom_addr_c;
   logic [HAW-1:0]    hist_raddr_c;

   // State and datapath registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         phase_q      <= '0;
         cur_phase_q  <= '0;
         wr_ptr_q     <= '0;
         pending_q    <= 1'b0;
         k_q          <= '0;
         rom_addr_q   <= '0;
         hist_raddr_q <= '0;
         en_pipe_q    <= '0;
         clr_pipe_q   <= '0;
      end else begin
         state_q      <= state_d;
         phase_q      <= phase_d;
         cur_phase_q  <= cur_phase_d;
         wr_ptr_q     <= wr_ptr_d;
         pending_q    <= pending_d;
         k_q          <= k_d;
         rom_addr_q   <= rom_addr_d;
         hist_raddr_q <= hist_raddr_d;
         en_pipe_q    <= en_pipe_d;
         clr_pipe_q   <= clr_pipe_d;
      end
   end

   // Phase rule and start-of-product decode shared by FSM and datapath
   always_comb begin
      phase_sum  = {1'b0, phase_q} + (PW+1)'(DECIM);
      need       = (phase_sum >= (PW+1)'(NPHASE));
      phase_next = need ? PW'(phase_sum - (PW+1)'(NPHASE)) : PW'(phase_sum);
      // A tick arriving in DONE is treated exactly like a pending tick
      start      = ((state_q == ST_IDLE) && out_tick) ||
                   ((state_q == ST_DONE) && (pending_q || out_tick));
      issue      = (state_q == ST_MAC);
      xfer       = (state_q == ST_FETCH) && in_valid;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start) state_d = need ? ST_FETCH : ST_MAC;
         ST_FETCH: if (in_valid) state_d = ST_MAC;
         ST_MAC:   if (k_q == HAW'(TAPS - 1)) state_d = ST_DRAIN;
         ST_DRAIN: if (k_q == HAW'(RD_LAT - 1)) state_d = ST_DONE;
         ST_DONE:  state_d = start ? (need ? ST_FETCH : ST_MAC) : ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Datapath: phase/pointer updates, tap counter, address hold, tick queueing
   always_comb begin
      phase_d     = phase_q;
      cur_phase_d = cur_phase_q;
      wr_ptr_d    = wr_ptr_q;
      pending_d   = pending_q;
      overrun_c   = 1'b0;

      if (start) begin
         phase_d     = phase_next;
         cur_phase_d = phase_q;
      end

      if (xfer) wr_ptr_d = wr_ptr_q + HAW'(1);

      // k counts taps in MAC, then drain cycles in DRAIN; cleared on any transition
      k_d = ((state_d == state_q) && ((state_q == ST_MAC) || (state_q == ST_DRAIN)))
            ? k_q + HAW'(1) : '0;

      case (state_q)
         ST_FETCH, ST_MAC, ST_DRAIN: begin
            if (out_tick) begin
               if (pending_q) overrun_c = 1'b1;
               else           pending_d = 1'b1;
            end
         end
         // Pending tick is consumed here; a fresh tick re-arms it
         ST_DONE: pending_d = pending_q && out_tick;
         default: pending_d = pending_q;
      endcase

      rom_addr_c   = RAW'(32'(cur_phase_q) * TAPS + 32'(k_q));
      hist_raddr_c = wr_ptr_q - HAW'(1) - k_q;
      rom_addr_d   = issue ? rom_addr_c   : rom_addr_q;
      hist_raddr_d = issue ? hist_raddr_c : hist_raddr_q;

      en_pipe_d[0]  = issue;
      clr_pipe_d[0] = issue && (k_q == '0);
      for (int unsigned i = 1; i < RD_LAT; i++) begin
         en_pipe_d[i]  = en_pipe_q[i-1];
         clr_pipe_d[i] = clr_pipe_q[i-1];
      end
   end

   // Output decode
   always_comb begin
      in_ready   = (state_q == ST_FETCH);
      hist_we    = xfer;
      hist_waddr = wr_ptr_q;
      rom_addr   = issue ? rom_addr_c   : rom_addr_q;
      hist_raddr = issue ? hist_raddr_c : hist_raddr_q;
      mac_en     = en_pipe_q[RD_LAT-1];
      mac_clr    = clr_pipe_q[RD_LAT-1];
      out_valid  = (state_q == ST_DONE);
      cur_phase  = cur_phase_q;
      overrun    = overrun_c;
   end

endmodule

// File: tb/tb_firbank_32_48_sequencer.sv
// Directed bench for firbank_32_48_sequencer. Inputs change on the falling
// edge, outputs are sampled 1 time unit later. Cycle t is the cycle in which
// out_tick is high; the DUT reacts from cycle t+1.
module tb_firbank_32_48_sequencer;

   logic       clk;
   logic       rst_n;
   logic       out_tick;
   logic       in_valid;
   logic       in_ready;
   logic       hist_we;
   logic [3:0] hist_waddr;
   logic [5:0] rom_addr;
   logic [3:0] hist_raddr;
   logic       mac_clr;
   logic       mac_en;
   logic       out_valid;
   logic [1:0] cur_phase;
   logic       overrun;

   logic [21:0] all_outs;
   int tests_run;
   int tests_failed;

   firbank_32_48_sequencer #(
      .TAPS   (16),
      .NPHASE (3),
      .DECIM  (2),
      .RD_LAT (1)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .out_tick   (out_tick),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .hist_we    (hist_we),
      .hist_waddr (hist_waddr),
      .rom_addr   (rom_addr),
      .hist_raddr (hist_raddr),
      .mac_clr    (mac_clr),
      .mac_en     (mac_en),
      .out_valid  (out_valid),
      .cur_phase  (cur_phase),
      .overrun    (overrun)
   );

   assign all_outs = {in_ready, hist_we, hist_waddr, rom_addr, hist_raddr,
                      mac_clr, mac_en, out_valid, cur_phase, overrun};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0; out_tick = 1'b0; in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); #1;
         tests_run++;
         if (all_outs !== '0) begin
            tests_failed++;
            $display("FAIL reset_outs cyc%0d: got %h expected 0", c, all_outs);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;                 // out_tick still high: first tick after release
      @(negedge clk);
      out_tick = 1'b0; #1;
      tests_run++;
      if (cur_phase !== 2'd0) begin
         tests_failed++; $display("FAIL reset_first_phase: got %0d expected 0", cur_phase);
      end
      tests_run++;
      if (in_ready !== 1'b0) begin
         tests_failed++; $display("FAIL reset_first_no_fetch: got %b expected 0", in_ready);
      end
      @(negedge clk); #1;
      tests_run++;
      if (rom_addr !== 6'd1) begin
         tests_failed++; $display("FAIL reset_first_mac: rom_addr got %0d expected 1", rom_addr);
      end
      repeat (20) @(negedge clk);
   endtask

   task automatic test_phase_seq();
      int exp_phase [6] = '{0, 2, 1, 0, 2, 1};
      logic exp_need [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      apply_reset();
      in_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); out_tick = 1'b1;
         @(negedge clk); out_tick = 1'b0; #1;
         tests_run++;
         if (cur_phase !== 2'(exp_phase[i])) begin
            tests_failed++;
            $display("FAIL seq_phase tick%0d: got %0d expected %0d", i + 1, cur_phase, exp_phase[i]);
         end
         tests_run++;
         if (hist_we !== exp_need[i] || in_ready !== exp_need[i]) begin
            tests_failed++;
            $display("FAIL seq_fetch tick%0d: we=%b rdy=%b expected %b", i + 1, hist_we, in_ready, exp_need[i]);
         end
         repeat (38) @(negedge clk);
      end
      #1;
      tests_run++;
      if (hist_waddr !== 4'd4) begin
         tests_failed++; $display("FAIL seq_wr_ptr: got %0d expected 4", hist_waddr);
      end
   endtask

   // Continues from test_phase_seq: phase register 0, wr_ptr 4
   task automatic test_dot_product();
      logic e_en, e_clr, e_ov;
      logic [5:0] e_rom;
      logic [3:0] e_hr;
      int k;
      in_valid = 1'b1;
      @(negedge clk); out_tick = 1'b1;
      @(negedge clk); out_tick = 1'b0; #1;
      tests_run++;
      if (cur_phase !== 2'd0 || in_ready !== 1'b0) begin
         tests_failed++; $display("FAIL dot_pre: phase=%0d rdy=%b expected 0/0", cur_phase, in_ready);
      end
      repeat (38) @(negedge clk);
      out_tick = 1'b1;
      for (int j = 1; j <= 21; j++) begin
         @(negedge clk); out_tick = 1'b0; #1;
         e_en  = (j >= 3) && (j <= 18);
         e_clr = (j == 3);
         e_ov  = (j == 19);
         tests_run++;
         if (mac_en !== e_en || mac_clr !== e_clr || out_valid !== e_ov) begin
            tests_failed++;
            $display("FAIL dot_ctrl j%0d: en=%b clr=%b ov=%b expected %b/%b/%b",
                     j, mac_en, mac_clr, out_valid, e_en, e_clr, e_ov);
         end
         if (j == 1) begin
            tests_run++;
            if (hist_we !== 1'b1 || hist_waddr !== 4'd4 || cur_phase !== 2'd2) begin
               tests_failed++;
               $display("FAIL dot_fetch: we=%b waddr=%0d phase=%0d expected 1/4/2", hist_we, hist_waddr, cur_phase);
            end
         end
         if (j >= 2 && j <= 17) begin
            k = j - 2;
            e_rom = 6'(32 + k);
            e_hr  = 4'((4 - k + 16) % 16);
            tests_run++;
            if (rom_addr !== e_rom || hist_raddr !== e_hr) begin
               tests_failed++;
               $display("FAIL dot_addr k%0d: rom=%0d hist=%0d expected %0d/%0d", k, rom_addr, hist_raddr, e_rom, e_hr);
            end
         end
         if (j == 19) begin
            tests_run++;
            if (rom_addr !== 6'd47 || hist_raddr !== 4'd5) begin
               tests_failed++;
               $display("FAIL dot_addr_hold: rom=%0d hist=%0d expected 47/5", rom_addr, hist_raddr);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic e_ov, e_out, e_en;
      apply_reset();
      in_valid = 1'b1;
      for (int j = 0; j < 40; j++) begin
         @(negedge clk);
         out_tick = (j == 0) || (j == 5) || (j == 10);
         #1;
         e_ov  = (j == 10);
         e_out = (j == 18) || (j == 37);
         e_en  = ((j >= 2) && (j <= 17)) || ((j >= 21) && (j <= 36));
         tests_run++;
         if (overrun !== e_ov || out_valid !== e_out || mac_en !== e_en) begin
            tests_failed++;
            $display("FAIL b2b j%0d: ovr=%b ov=%b en=%b expected %b/%b/%b",
                     j, overrun, out_valid, mac_en, e_ov, e_out, e_en);
         end
         if (j == 19) begin
            tests_run++;
            if (in_ready !== 1'b1 || cur_phase !== 2'd2) begin
               tests_failed++;
               $display("FAIL b2b_restart: rdy=%b phase=%0d expected 1/2", in_ready, cur_phase);
            end
         end
         if (j == 20) begin
            tests_run++;
            if (rom_addr !== 6'd32) begin
               tests_failed++; $display("FAIL b2b_second_mac: rom=%0d expected 32", rom_addr);
            end
         end
      end
      out_tick = 1'b0;
   endtask

   task automatic test_fetch_stall();
      apply_reset();
      in_valid = 1'b0;
      @(negedge clk); out_tick = 1'b1;
      @(negedge clk); out_tick = 1'b0;
      repeat (22) @(negedge clk);
      out_tick = 1'b1;               // phase-2 tick: needs a sample
      for (int j = 1; j <= 50; j++) begin
         @(negedge clk); out_tick = 1'b0; #1;
         tests_run++;
         if (in_ready !== 1'b1 || mac_en !== 1'b0 || hist_we !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall j%0d: rdy=%b en=%b we=%b expected 1/0/0", j, in_ready, mac_en, hist_we);
         end
      end
      @(negedge clk); in_valid = 1'b1; #1;
      tests_run++;
      if (hist_we !== 1'b1 || hist_waddr !== 4'd0) begin
         tests_failed++; $display("FAIL stall_xfer: we=%b waddr=%0d expected 1/0", hist_we, hist_waddr);
      end
      @(negedge clk); in_valid = 1'b0; #1;
      tests_run++;
      if (in_ready !== 1'b0 || rom_addr !== 6'd32 || hist_raddr !== 4'd0) begin
         tests_failed++;
         $display("FAIL stall_mac: rdy=%b rom=%0d hist=%0d expected 0/32/0", in_ready, rom_addr, hist_raddr);
      end
      @(negedge clk); #1;
      tests_run++;
      if (mac_en !== 1'b1 || mac_clr !== 1'b1) begin
         tests_failed++; $display("FAIL stall_first_en: en=%b clr=%b expected 1/1", mac_en, mac_clr);
      end
      repeat (20) @(negedge clk);
   endtask

   task automatic test_reset_mid_mac();
      apply_reset();
      in_valid = 1'b1;
      @(negedge clk); out_tick = 1'b1;
      @(negedge clk); out_tick = 1'b0;
      repeat (22) @(negedge clk);
      out_tick = 1'b1;               // phase 2, fetch at t+1, MAC from t+2
      for (int j = 1; j <= 9; j++) begin
         @(negedge clk); out_tick = 1'b0;
      end
      #1;
      tests_run++;
      if (rom_addr !== 6'd39) begin
         tests_failed++; $display("FAIL mid_mac_k7: rom=%0d expected 39", rom_addr);
      end
      rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1; #1;
      tests_run++;
      if (all_outs !== '0) begin
         tests_failed++; $display("FAIL mid_reset_outs: got %h expected 0", all_outs);
      end
      for (int j = 0; j < 20; j++) begin
         @(negedge clk); #1;
         tests_run++;
         if (out_valid !== 1'b0 || mac_en !== 1'b0) begin
            tests_failed++; $display("FAIL mid_aborted j%0d: ov=%b en=%b expected 0/0", j, out_valid, mac_en);
         end
      end
      @(negedge clk); out_tick = 1'b1;
      @(negedge clk); out_tick = 1'b0; #1;
      tests_run++;
      if (cur_phase !== 2'd0 || in_ready !== 1'b0 || hist_waddr !== 4'd0) begin
         tests_failed++;
         $display("FAIL mid_restart: phase=%0d rdy=%b waddr=%0d expected 0/0/0", cur_phase, in_ready, hist_waddr);
      end
      @(negedge clk); #1;
      tests_run++;
      if (rom_addr !== 6'd1) begin
         tests_failed++; $display("FAIL mid_restart_mac: rom=%0d expected 1", rom_addr);
      end
      repeat (20) @(negedge clk);
      out_tick = 1'b1;
      @(negedge clk); out_tick = 1'b0; #1;
      tests_run++;
      if (cur_phase !== 2'd2 || in_ready !== 1'b1 || hist_waddr !== 4'd0) begin
         tests_failed++;
         $display("FAIL mid_second: phase=%0d rdy=%b waddr=%0d expected 2/1/0", cur_phase, in_ready, hist_waddr);
      end
      repeat (22) @(negedge clk);
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst_n    = 1'b0;
      out_tick = 1'b1;
      in_valid = 1'b0;
      test_reset();
      test_phase_seq();
      test_dot_product();
      test_back_to_back();
      test_fetch_stall();
      test_reset_mid_mac();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
